ram64_fifo_ctrl: RTL and testbench
==================================

// Module: ram64_fifo_ctrl
// PURPOSE
// - Sequences a bank of 64x1 dual-port distributed RAMs (one primitive per data bit) as a synchronous FIFO.
// - Drives the shared write address, write enable and write data. Drives the independent read address.
// - Returns the asynchronous read data as a first-word-fall-through valid/ready stream.
// - Sits between a producer and a consumer in the same clock domain. The RAM bank is instantiated outside this block.
// PARAMETERS
// - WIDTH  8   data bits per entry (RAM primitives per lane)
// - DEPTH  64  usable entries, 2..64; pointers wrap at DEPTH-1 (need not be a power of 2)
// PORTS
// - clk        in   1      single clock; also drives RAM WCLK
// - rst        in   1      synchronous, active-high reset
// - flush      in   1      synchronous clear of pointers/count
// - in_valid   in   1      producer has data
// - in_ready   out  1      FIFO accepts data this cycle
// - in_data    in   WIDTH  push data
// - out_valid  out  1      head entry available
// - out_ready  in   1      consumer takes head this cycle
// - out_data   out  WIDTH  head entry (from ram_rdata)
// - ram_we     out  1      to RAM WE
// - ram_waddr  out  6      to RAM A5..A0
// - ram_wdata  out  RW     to RAM D lanes; RW=WIDTH, or WIDTH+1 with parity
// - ram_raddr  out  6      to RAM DPRA5..DPRA0
// - ram_rdata  in   RW     from RAM DPO lanes (combinational)
// - count      out  7      occupancy, 0..DEPTH
// - out_perr   out  1      sticky parity error (parity build only)
// BEHAVIOUR
// - Reset (rst=1 at posedge):
//   - wptr, rptr and count go to 0; out_perr goes to 0.
//   - Outputs after reset: in_ready=1, out_valid=0, ram_we=0.
//   - rst overrides flush and any push or pop in that cycle.
//   - RAM contents are not cleared.
// - in_ready = (count != DEPTH) & ~flush. It is combinational and does not depend on out_ready (no full bypass).
// - Push: push = in_valid & in_ready.
//   - ram_we = push, ram_waddr = wptr, ram_wdata = in_data, all combinational.
//   - The RAM writes at the same edge. wptr advances by 1 and wraps from DEPTH-1 to 0.
// - out_valid = (count != 0).
// - Pop: pop = out_valid & out_ready & ~flush.
//   - ram_raddr = rptr, out_data = ram_rdata[WIDTH-1:0].
//   - rptr advances by 1 and wraps from DEPTH-1 to 0.
// - Latency:
//   - A push into an empty FIFO shows out_valid=1 and the data on the next cycle. The RAM write becomes visible on DPO after the edge.
//   - Pop-to-next-head latency is 0 cycles.
// - count update: +1 on push only, -1 on pop only, unchanged on both or neither.
// - Boundary conditions:
//   - Push and pop in the same cycle are legal whenever 0 < count < DEPTH. Addresses differ, so there is no RAM collision.
//   - When empty, wptr == rptr. Write data is not bypassed to out_data.
//   - When full, no push is accepted; a pop frees one entry, visible the next cycle.
//   - flush=1 sets wptr, rptr and count to 0 at the edge and drops the push and pop of that cycle.
//   - Upper ram_waddr/ram_raddr bits are 0 when DEPTH < 64.
// - Invariant: count == (wptr - rptr) mod DEPTH, except when full (count = DEPTH, wptr == rptr).
// CONFIGURATION
// - Macro RAM64_FIFO_PARITY_EN defined:
//   - RW = WIDTH+1; ram_wdata[WIDTH] = ^in_data (even parity).
//   - On each pop, if ^ram_rdata != 0, out_perr is set at the edge and stays set until rst. flush does not clear it.
// - Macro not defined:
//   - RW = WIDTH, no extra RAM lane, out_perr tied to 0.
// TESTING
// - Reset to empty: rst 2 cycles -> count=0, in_ready=1, out_valid=0, ram_we=0; out_ready=1 gives no pop.
// - Fill and drain: DEPTH=64, push 0x00..0x3F back-to-back with out_ready=0.
//   - After 64 pushes: count=64, in_ready=0; a 65th in_valid is ignored.
//   - Then drain: data 0x00..0x3F in order, count back to 0.
// - Wrap and simultaneous: DEPTH=48, hold count=5 with push+pop every cycle for 200 cycles.
//   - count stays 5; wptr wraps 47->0; output sequence equals input sequence.
// - Full-edge pop: at count=DEPTH, pop once -> in_ready=1 next cycle.
//   - A push that cycle lands at the old rptr address; count returns to DEPTH.
// - Flush mid-stream: at count=10, assert flush with in_valid=1 and out_ready=1.
//   - Next cycle: count=0, out_valid=0; the dropped push is never output.
// - Parity (RAM64_FIFO_PARITY_EN): push 0xA5, corrupt ram_rdata[WIDTH] in the RAM model, pop.
//   - out_perr=1 from the next cycle, held through flush; clears only on rst.

Source files
------------

// File: rtl/ram64_fifo_ctrl.sv
// rtl/ram64_fifo_ctrl.sv - FWFT FIFO sequencer for a bank of 64x1 dual-port distributed RAMs
// Optional even-parity lane and sticky parity error enabled by RAM64_FIFO_PARITY_EN.
module ram64_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
`ifdef RAM64_FIFO_PARITY_EN
    localparam int RW = WIDTH + 1
`else
    localparam int RW = WIDTH
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             ram_we,
    output logic [5:0]       ram_waddr,
    output logic [RW-1:0]    ram_wdata,
    output logic [5:0]       ram_raddr,
    input  logic [RW-1:0]    ram_rdata,
    output logic [6:0]       count,
    output logic             out_perr
);

    localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);
    localparam logic [6:0] FULL_CNT = 7'(DEPTH);

    logic [5:0] wptr_q, wptr_d;
    logic [5:0] rptr_q, rptr_d;
    logic [6:0] count_q, count_d;
    logic       push;
    logic       pop;

    // Handshakes: in_ready deliberately ignores out_ready, so a full FIFO never
    // accepts a push even when the head is being taken in the same cycle.
    always_comb begin
        in_ready  = (count_q != FULL_CNT) && !flush;
        out_valid = (count_q != 7'd0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready && !flush;
    end

    always_comb begin
        ram_we    = push;
        ram_waddr = wptr_q;
        ram_raddr = rptr_q;
        out_data  = ram_rdata[WIDTH-1:0];
        count     = count_q;
`ifdef RAM64_FIFO_PARITY_EN
        ram_wdata = {^in_data, in_data};
`else
        ram_wdata = in_data;
`endif
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = 6'd0;
            rptr_d  = 6'd0;
            count_d = 7'd0;
        end else begin
            if (push) begin
                wptr_d = (wptr_q == LAST_IDX) ? 6'd0 : wptr_q + 6'd1;
            end
            if (pop) begin
                rptr_d = (rptr_q == LAST_IDX) ? 6'd0 : rptr_q + 6'd1;
            end
            if (push && !pop) begin
                count_d = count_q + 7'd1;
            end else if (pop && !push) begin
                count_d = count_q - 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= 6'd0;
            rptr_q  <= 6'd0;
            count_q <= 7'd0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

`ifdef RAM64_FIFO_PARITY_EN
    logic perr_q, perr_d;

    // Sticky until reset; flush intentionally leaves it alone.
    always_comb begin
        perr_d = perr_q;
        if (pop && (^ram_rdata)) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign out_perr = perr_q;
`else
    assign out_perr = 1'b0;
`endif

endmodule

// File: tb/tb_ram64_fifo_ctrl.sv
// tb/tb_ram64_fifo_ctrl.sv - directed self-checking bench for ram64_fifo_ctrl (DEPTH 64 and 48 instances)
module tb_ram64_fifo_ctrl;

`ifdef RAM64_FIFO_PARITY_EN
    localparam int RW = 9;
`else
    localparam int RW = 8;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [1:0]          flush_s = '0;
    logic [1:0]          in_valid_s = '0;
    logic [1:0]          in_ready_s;
    logic [1:0][7:0]     in_data_s = '0;
    logic [1:0]          out_valid_s;
    logic [1:0]          out_ready_s = '0;
    logic [1:0][7:0]     out_data_s;
    logic [1:0]          ram_we_s;
    logic [1:0][5:0]     ram_waddr_s;
    logic [1:0][RW-1:0]  ram_wdata_s;
    logic [1:0][5:0]     ram_raddr_s;
    logic [1:0][RW-1:0]  ram_rdata_s;
    logic [1:0][6:0]     count_s;
    logic [1:0]          out_perr_s;

    logic [RW-1:0] mem0 [64];
    logic [RW-1:0] mem1 [64];
    logic [63:0]   flip0 = '0;

    int n_chk = 0;
    int n_fail = 0;
    int cnt [2];
    int wp [2];
    int rp [2];
    logic [1:0] exp_perr = '0;
    logic corrupt_pend = 1'b0;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    always #5 clk = ~clk;

    ram64_fifo_ctrl #(.WIDTH(8), .DEPTH(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush_s[0]),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_data(in_data_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_data(out_data_s[0]),
        .ram_we(ram_we_s[0]), .ram_waddr(ram_waddr_s[0]), .ram_wdata(ram_wdata_s[0]),
        .ram_raddr(ram_raddr_s[0]), .ram_rdata(ram_rdata_s[0]),
        .count(count_s[0]), .out_perr(out_perr_s[0])
    );

    ram64_fifo_ctrl #(.WIDTH(8), .DEPTH(48)) dut48 (
        .clk(clk), .rst(rst), .flush(flush_s[1]),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_data(in_data_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_data(out_data_s[1]),
        .ram_we(ram_we_s[1]), .ram_waddr(ram_waddr_s[1]), .ram_wdata(ram_wdata_s[1]),
        .ram_raddr(ram_raddr_s[1]), .ram_rdata(ram_rdata_s[1]),
        .count(count_s[1]), .out_perr(out_perr_s[1])
    );

    // 64x1 RAM bank models: synchronous write, combinational DPO read.
    always @(posedge clk) begin
        if (ram_we_s[0]) mem0[ram_waddr_s[0]] <= ram_wdata_s[0];
        if (ram_we_s[1]) mem1[ram_waddr_s[1]] <= ram_wdata_s[1];
    end

`ifdef RAM64_FIFO_PARITY_EN
    assign ram_rdata_s[0] = mem0[ram_raddr_s[0]] ^ {flip0[ram_raddr_s[0]], 8'h00};
`else
    assign ram_rdata_s[0] = mem0[ram_raddr_s[0]];
`endif
    assign ram_rdata_s[1] = mem1[ram_raddr_s[1]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int dep(input int s);
        return (s == 0) ? 64 : 48;
    endfunction

    task automatic model_clear(input int s);
        cnt[s] = 0;
        wp[s]  = 0;
        rp[s]  = 0;
        if (s == 0) q0.delete();
        else        q1.delete();
    endtask

    // One clock on instance s: drive, check combinational outputs, clock, check count.
    task automatic cyc(input int s, input logic v, input logic [7:0] d, input logic r, input logic f);
        logic ex_push;
        logic ex_pop;
        logic [7:0] head;
        logic [RW-1:0] exp_wd;
        in_valid_s  = '0;
        out_ready_s = '0;
        flush_s     = '0;
        in_valid_s[s]  = v;
        in_data_s[s]   = d;
        out_ready_s[s] = r;
        flush_s[s]     = f;
        #1;
        ex_push = v && (cnt[s] != dep(s)) && !f;
        ex_pop  = (cnt[s] != 0) && r && !f;
`ifdef RAM64_FIFO_PARITY_EN
        exp_wd = {^d, d};
`else
        exp_wd = d;
`endif
        chk("in_ready", 32'(in_ready_s[s]), 32'((cnt[s] != dep(s)) && !f));
        chk("out_valid", 32'(out_valid_s[s]), 32'(cnt[s] != 0));
        chk("ram_we", 32'(ram_we_s[s]), 32'(ex_push));
        chk("ram_raddr", 32'(ram_raddr_s[s]), 32'(rp[s]));
        if (ex_push) begin
            chk("ram_waddr", 32'(ram_waddr_s[s]), 32'(wp[s]));
            chk("ram_wdata", 32'(ram_wdata_s[s]), 32'(exp_wd));
        end
        if (cnt[s] != 0) begin
            head = (s == 0) ? q0[0] : q1[0];
            chk("out_data", 32'(out_data_s[s]), 32'(head));
        end
        chk("out_perr", 32'(out_perr_s[s]), 32'(exp_perr[s]));
        @(posedge clk);
        if (f) begin
            model_clear(s);
        end else begin
            if (ex_push) begin
                if (s == 0) q0.push_back(d);
                else        q1.push_back(d);
                wp[s] = (wp[s] == dep(s) - 1) ? 0 : wp[s] + 1;
                cnt[s]++;
            end
            if (ex_pop) begin
                if (s == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                rp[s] = (rp[s] == dep(s) - 1) ? 0 : rp[s] + 1;
                cnt[s]--;
                if (s == 0 && corrupt_pend) begin
                    exp_perr[0] = 1'b1;
                    corrupt_pend = 1'b0;
                end
            end
        end
        #1;
        chk("count", 32'(count_s[s]), 32'(cnt[s]));
    endtask

    // Reset with pushes and pops requested; both must be dropped.
    task automatic do_reset();
        rst = 1'b1;
        in_valid_s  = '1;
        out_ready_s = '1;
        flush_s     = '0;
        in_data_s   = {8'h5A, 8'h5A};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count0", 32'(count_s[0]), 32'd0);
        chk("rst_count1", 32'(count_s[1]), 32'd0);
        chk("rst_perr0", 32'(out_perr_s[0]), 32'd0);
        rst = 1'b0;
        in_valid_s  = '0;
        out_ready_s = '0;
        model_clear(0);
        model_clear(1);
        exp_perr = '0;
    endtask

    initial begin
        do_reset();
        cyc(0, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1, 1'b0, 8'h00, 1'b1, 1'b0);

        // Fill DEPTH=64 with 0x00..0x3F, then a rejected 65th push, then drain.
        for (int i = 0; i < 64; i++) cyc(0, 1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_count", 32'(count_s[0]), 32'd64);
        chk("fill_in_ready", 32'(in_ready_s[0]), 32'd0);
        cyc(0, 1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            chk("drain_order", 32'(out_data_s[0]), 32'(i));
            cyc(0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(count_s[0]), 32'd0);

        // DEPTH=48: hold five entries with simultaneous push/pop across several wraps.
        for (int i = 0; i < 5; i++) cyc(1, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) cyc(1, 1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
        chk("wrap_count", 32'(count_s[1]), 32'd5);
        chk("wrap_wptr", 32'(ram_waddr_s[1]), 32'((5 + 200) % 48));

        // Full-edge pop then refill into the slot just freed.
        for (int i = 0; i < 64; i++) cyc(0, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        cyc(0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("fullpop_ready", 32'(in_ready_s[0]), 32'd1);
        chk("fullpop_waddr", 32'(ram_waddr_s[0]), 32'd0);
        cyc(0, 1'b1, 8'h99, 1'b0, 1'b0);
        chk("fullpop_refill", 32'(count_s[0]), 32'd64);

        // Flush mid-stream with a push and pop both requested.
        cyc(0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        cyc(0, 1'b1, 8'h77, 1'b1, 1'b1);
        chk("flush_valid", 32'(out_valid_s[0]), 32'd0);
        cyc(0, 1'b1, 8'h11, 1'b0, 1'b0);
        cyc(0, 1'b1, 8'h22, 1'b1, 1'b0);
        cyc(0, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_drained", 32'(count_s[0]), 32'd0);

`ifdef RAM64_FIFO_PARITY_EN
        do_reset();
        cyc(0, 1'b1, 8'hA5, 1'b0, 1'b0);
        flip0[rp[0]] = 1'b1;
        corrupt_pend = 1'b1;
        cyc(0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("perr_set", 32'(out_perr_s[0]), 32'd1);
        cyc(0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("perr_after_flush", 32'(out_perr_s[0]), 32'd1);
        do_reset();
        cyc(0, 1'b0, 8'h00, 1'b0, 1'b0);
`else
        chk("perr_tied", 32'(out_perr_s[0]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
